cart_load_ctrl: RTL and testbench
=================================

// Module: cart_load_ctrl
// PURPOSE
//  Sequences a cartridge ROM download from the ioctl stream into SDRAM and feeds the ROM-type detector.
//  Per byte: latches ioctl data, stalls the host via ioctl_wait, writes SDRAM with a req/ack handshake,
//  then pulses det_we so the detector sees exactly the bytes that were stored.
//  After the download ends it waits for the detector outputs to settle, then commits mapper/offset/size
//  (or a user override) to the slot config and pulses a cartridge reset.
// PARAMETERS
//  ROM_INDEX    8'h01     ioctl_index value that selects this cartridge download
//  SDRAM_BASE   25'h0     SDRAM byte address of ROM byte 0
//  MAX_SIZE     25'h400000 bytes accepted; later bytes dropped, overflow flag set
//  SETTLE_CYC   4         clk cycles between end of download and commit (>=2)
//  RST_CYC      16        length of cart_reset pulse in clk cycles
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous active-high reset
//  ioctl_download in   1   host download active
//  ioctl_index    in   8   download target
//  ioctl_wr       in   1   1-cycle byte strobe
//  ioctl_addr     in   25  byte address within image
//  ioctl_dout     in   8   byte data
//  ioctl_wait     out  1   host stall; high while a byte is in flight
//  mem_req        out  1   SDRAM write request, held until mem_ack
//  mem_addr       out  25  SDRAM_BASE + latched ioctl_addr
//  mem_din        out  8   latched byte
//  mem_ack        in   1   1-cycle write-complete
//  det_isROM      out  1   to detector: high while in LOAD/WRITE/SETTLE (rising edge clears its counters)
//  det_we         out  1   to detector: 1-cycle pulse per stored byte
//  det_addr       out  25  to detector: latched ioctl_addr, valid with det_we
//  det_dout       out  8   to detector: latched byte, valid with det_we
//  det_mapper     in   3   from detector
//  det_offset     in   4   from detector
//  det_size       in   25  from detector
//  user_mapper    in   3   0 = auto; nonzero forces mapper value at commit
//  cart_mapper    out  3   committed mapper
//  cart_offset    out  4   committed offset (x4000 page units)
//  cart_size      out  25  committed size in bytes
//  cart_valid     out  1   committed config valid
//  cart_reset     out  1   reset pulse to slot logic after commit
//  overflow       out  1   image exceeded MAX_SIZE (sticky until next download)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; cart_* registers 0. Reset mid-download aborts: mem_req drops, no commit.
//  Active download: act = ioctl_download && ioctl_index==ROM_INDEX.
//  FSM: IDLE -> LOAD on act rising (registered edge): cart_valid<=0, overflow<=0, det_isROM<=1.
//   LOAD: ioctl_wr && addr<MAX_SIZE -> latch addr/data, ioctl_wait<=1, mem_req<=1, -> WRITE (same edge).
//         ioctl_wr && addr>=MAX_SIZE -> overflow<=1, byte dropped, no wait, no det_we.
//         !act -> SETTLE.
//   WRITE: hold mem_req/addr/din stable; on mem_ack: mem_req<=0, ioctl_wait<=0, det_we<=1 (1 cycle),
//         -> LOAD. act falling while in WRITE is ignored until ack; then LOAD sees !act -> SETTLE.
//         ack arriving in the same cycle as req assertion is impossible (req is registered); ack with
//         mem_req low is ignored.
//   SETTLE: counter from SETTLE_CYC-1 to 0, det_isROM stays 1; at 0 -> COMMIT.
//   COMMIT (1 cycle): cart_mapper<=user_mapper!=0 ? user_mapper : det_mapper; cart_offset<=det_offset;
//         cart_size<=det_size; cart_valid<=1; cart_reset<=1; det_isROM<=0; -> RSTP.
//   RSTP: cart_reset held RST_CYC cycles total, then 0 -> IDLE.
//   New act rising during SETTLE/COMMIT/RSTP: finish current sequence to IDLE, then start LOAD next cycle
//   (edge is latched in a pending flag).
//  Zero-byte download (no det_we): commit still occurs; det_size as reported (detector returns 0 -> mapper 0).
//  Latency: ioctl_wr to mem_req = 1 cycle; mem_ack to det_we = 1 cycle; ioctl_wait drops with det_we rising.
//  user_mapper sampled only in COMMIT; later changes do not alter cart_mapper.
// TESTING
//  32 KiB image, mem_ack 3 cycles after req -> 32768 mem writes, addrs SDRAM_BASE..+7FFF, 32768 det_we, wait per byte.
//  End download mid-WRITE -> ack completes, det_we pulses, SETTLE_CYC cycles later COMMIT; cart_size=0x8000.
//  user_mapper=3, detector reports 5 -> cart_mapper=3; user_mapper=0 -> cart_mapper=5; cart_reset high RST_CYC.
//  MAX_SIZE=0x100, 0x200-byte image -> 256 writes only, overflow=1, ioctl_wait never set for addr>=0x100.
//  reset asserted in WRITE -> next cycle mem_req=0, ioctl_wait=0, cart_valid=0, state IDLE.
//  Second download starts during RSTP -> cart_valid 1 until IDLE, then 0 and LOAD next cycle.

Source files
------------

// File: rtl/cart_load_ctrl.sv
`default_nettype none
// ============================================================================
// cart_load_ctrl : streams a cartridge ROM image from ioctl into SDRAM, feeds
//                  the ROM-type detector and commits the resulting slot config.
// Revision 1.0
// ============================================================================
module cart_load_ctrl #(
    parameter logic [7:0]  ROM_INDEX  = 8'h01,
    parameter logic [24:0] SDRAM_BASE = 25'h0,
    parameter logic [24:0] MAX_SIZE   = 25'h400000,
    parameter int          SETTLE_CYC = 4,
    parameter int          RST_CYC    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic        det_isROM,
    output logic        det_we,
    output logic [24:0] det_addr,
    output logic [7:0]  det_dout,
    input  logic [2:0]  det_mapper,
    input  logic [3:0]  det_offset,
    input  logic [24:0] det_size,
    input  logic [2:0]  user_mapper,
    output logic [2:0]  cart_mapper,
    output logic [3:0]  cart_offset,
    output logic [24:0] cart_size,
    output logic        cart_valid,
    output logic        cart_reset,
    output logic        overflow
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYC - 1);
    localparam logic [RCW-1:0] RST_LOAD    = RCW'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
        S_SETTLE = 3'd3,
        S_COMMIT = 3'd4,
        S_RSTP   = 3'd5
    } state_t;

    state_t         state, state_n;
    logic           act, act_d, act_rise;
    logic           pending, pending_n;
    logic [SCW-1:0] settle_cnt, settle_cnt_n;
    logic [RCW-1:0] rst_cnt, rst_cnt_n;
    logic [24:0]    lat_addr, lat_addr_n;
    logic [7:0]     lat_data, lat_data_n;
    logic [24:0]    mem_addr_n;
    logic           mem_req_n, ioctl_wait_n, det_we_n, det_isrom_n;
    logic [2:0]     cart_mapper_n;
    logic [3:0]     cart_offset_n;
    logic [24:0]    cart_size_n;
    logic           cart_valid_n, cart_reset_n, overflow_n;

    assign act      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign act_rise = act && !act_d;

    // Both sinks see the same latched byte, so the detector only ever observes stored data.
    assign mem_din  = lat_data;
    assign det_dout = lat_data;
    assign det_addr = lat_addr;

    always_comb begin
        state_n       = state;
        pending_n     = pending;
        settle_cnt_n  = settle_cnt;
        rst_cnt_n     = rst_cnt;
        lat_addr_n    = lat_addr;
        lat_data_n    = lat_data;
        mem_addr_n    = mem_addr;
        mem_req_n     = mem_req;
        ioctl_wait_n  = ioctl_wait;
        det_we_n      = 1'b0;
        det_isrom_n   = det_isROM;
        cart_mapper_n = cart_mapper;
        cart_offset_n = cart_offset;
        cart_size_n   = cart_size;
        cart_valid_n  = cart_valid;
        cart_reset_n  = cart_reset;
        overflow_n    = overflow;

        // A new download arriving while the previous one is still being wrapped up.
        if (act_rise && (state inside {S_SETTLE, S_COMMIT, S_RSTP})) begin
            pending_n = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (act_rise || pending) begin
                    state_n      = S_LOAD;
                    pending_n    = 1'b0;
                    cart_valid_n = 1'b0;
                    overflow_n   = 1'b0;
                    det_isrom_n  = 1'b1;
                end
            end
            S_LOAD: begin
                if (!act) begin
                    state_n      = S_SETTLE;
                    settle_cnt_n = SETTLE_LOAD;
                end else if (ioctl_wr) begin
                    if (ioctl_addr < MAX_SIZE) begin
                        lat_addr_n   = ioctl_addr;
                        lat_data_n   = ioctl_dout;
                        mem_addr_n   = SDRAM_BASE + ioctl_addr;
                        mem_req_n    = 1'b1;
                        ioctl_wait_n = 1'b1;
                        state_n      = S_WRITE;
                    end else begin
                        overflow_n = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    mem_req_n    = 1'b0;
                    ioctl_wait_n = 1'b0;
                    det_we_n     = 1'b1;
                    state_n      = S_LOAD;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_n = S_COMMIT;
                end else begin
                    settle_cnt_n = settle_cnt - 1'b1;
                end
            end
            S_COMMIT: begin
                cart_mapper_n = (user_mapper != 3'd0) ? user_mapper : det_mapper;
                cart_offset_n = det_offset;
                cart_size_n   = det_size;
                cart_valid_n  = 1'b1;
                cart_reset_n  = 1'b1;
                det_isrom_n   = 1'b0;
                rst_cnt_n     = RST_LOAD;
                state_n       = S_RSTP;
            end
            S_RSTP: begin
                if (rst_cnt == '0) begin
                    cart_reset_n = 1'b0;
                    state_n      = S_IDLE;
                end else begin
                    rst_cnt_n = rst_cnt - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            act_d       <= 1'b0;
            pending     <= 1'b0;
            settle_cnt  <= '0;
            rst_cnt     <= '0;
            lat_addr    <= '0;
            lat_data    <= '0;
            mem_addr    <= '0;
            mem_req     <= 1'b0;
            ioctl_wait  <= 1'b0;
            det_we      <= 1'b0;
            det_isROM   <= 1'b0;
            cart_mapper <= '0;
            cart_offset <= '0;
            cart_size   <= '0;
            cart_valid  <= 1'b0;
            cart_reset  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            act_d       <= act;
            pending     <= pending_n;
            settle_cnt  <= settle_cnt_n;
            rst_cnt     <= rst_cnt_n;
            lat_addr    <= lat_addr_n;
            lat_data    <= lat_data_n;
            mem_addr    <= mem_addr_n;
            mem_req     <= mem_req_n;
            ioctl_wait  <= ioctl_wait_n;
            det_we      <= det_we_n;
            det_isROM   <= det_isrom_n;
            cart_mapper <= cart_mapper_n;
            cart_offset <= cart_offset_n;
            cart_size   <= cart_size_n;
            cart_valid  <= cart_valid_n;
            cart_reset  <= cart_reset_n;
            overflow    <= overflow_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cart_load_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_cart_load_ctrl : vector table, hand sequences and random downloads checked
//                     against a byte-level model of what must reach SDRAM.
// Revision 1.0
// ============================================================================
module tb_cart_load_ctrl;

    localparam logic [24:0] BASE   = 25'h0012000;
    localparam logic [24:0] MAX    = 25'h0000100;
    localparam int          SETTLE = 4;
    localparam int          RSTC   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        mem_req, mem_ack;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        det_isROM, det_we;
    logic [24:0] det_addr;
    logic [7:0]  det_dout;
    logic [2:0]  det_mapper, user_mapper, cart_mapper;
    logic [3:0]  det_offset, cart_offset;
    logic [24:0] det_size, cart_size;
    logic        cart_valid, cart_reset, overflow;

    always #5 clk = ~clk;

    cart_load_ctrl #(
        .ROM_INDEX (8'h01),
        .SDRAM_BASE(BASE),
        .MAX_SIZE  (MAX),
        .SETTLE_CYC(SETTLE),
        .RST_CYC   (RSTC)
    ) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
        .det_isROM(det_isROM), .det_we(det_we), .det_addr(det_addr), .det_dout(det_dout),
        .det_mapper(det_mapper), .det_offset(det_offset), .det_size(det_size),
        .user_mapper(user_mapper),
        .cart_mapper(cart_mapper), .cart_offset(cart_offset), .cart_size(cart_size),
        .cart_valid(cart_valid), .cart_reset(cart_reset), .overflow(overflow)
    );

    int          checks = 0;
    int          errors = 0;
    int          ack_lat = 3;
    int          stab_bad = 0;
    logic        force_ack = 1'b0;
    logic [32:0] mem_q[$], det_q[$], exp_mem[$], exp_det[$];

    typedef struct {
        int          n;
        logic [24:0] start;
        logic [2:0]  user;
        logic [2:0]  dmap;
        logic [3:0]  doff;
        logic [24:0] dsize;
        int          lat;
        bit          mid_end;
        logic [2:0]  exp_map;
        logic        exp_ovf;
        int          exp_n;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SDRAM responder and detector tap, evaluated mid-cycle.
    initial begin
        int          cnt;
        logic [32:0] cur;
        cnt = 0;
        cur = '0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = force_ack;
            if (det_we) det_q.push_back({det_addr, det_dout});
            if (reset || !mem_req) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    cur = {mem_addr, mem_din};
                    mem_q.push_back(cur);
                end else if ({mem_addr, mem_din} != cur) begin
                    stab_bad++;
                end
                cnt++;
                if (cnt >= ack_lat) begin
                    mem_ack = 1'b1;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit drop);
        int g;
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
        if (drop) ioctl_download = 1'b0;
        if (a < MAX) begin
            exp_mem.push_back({BASE + a, d});
            exp_det.push_back({a, d});
            check("wait_set", ioctl_wait, 1);
            check("req_lat", mem_req, 1);
        end else begin
            check("wait_ovf", ioctl_wait, 0);
        end
        g = 0;
        while (ioctl_wait && g < 100) begin tick(); g++; end
        if (g >= 100) check("wait_timeout", ioctl_wait, 0);
        if (a < MAX) check("det_we_at_wait_drop", det_we, 1);
    endtask

    task automatic begin_dl(input int lat, input logic [2:0] user, input logic [2:0] dmap,
                            input logic [3:0] doff, input logic [24:0] dsize);
        mem_q.delete(); det_q.delete(); exp_mem.delete(); exp_det.delete();
        ack_lat = lat; user_mapper = user; det_mapper = dmap; det_offset = doff; det_size = dsize;
        ioctl_index = 8'h01;
        ioctl_download = 1'b1;
        tick();
        check("load_isrom", det_isROM, 1);
        check("load_valid_clr", cart_valid, 0);
        check("load_ovf_clr", overflow, 0);
    endtask

    task automatic finish_dl(input logic [2:0] exp_map, input logic [3:0] doff,
                             input logic [24:0] dsize, input logic exp_ovf, input int exp_n);
        int cyc;
        ioctl_download = 1'b0;
        cyc = 0;
        while (!cart_valid && cyc < 200) begin tick(); cyc++; end
        check("settle_lat", cyc, SETTLE + 2);
        check("cart_mapper", cart_mapper, exp_map);
        check("cart_offset", cart_offset, doff);
        check("cart_size", cart_size, dsize);
        check("overflow", overflow, exp_ovf);
        check("cart_reset_on", cart_reset, 1);
        check("isrom_off", det_isROM, 0);
        user_mapper = user_mapper + 3'd1;
        cyc = 0;
        while (cart_reset && cyc < 200) begin tick(); cyc++; end
        check("rst_len", cyc, RSTC);
        check("mapper_hold", cart_mapper, exp_map);
        check("valid_after_rst", cart_valid, 1);
        check("n_mem", mem_q.size(), exp_n);
        check("n_det", det_q.size(), exp_n);
        for (int i = 0; i < mem_q.size() && i < exp_mem.size(); i++)
            check("mem_write", mem_q[i], exp_mem[i]);
        for (int i = 0; i < det_q.size() && i < exp_det.size(); i++)
            check("det_byte", det_q[i], exp_det[i]);
    endtask

    task automatic do_download(input vec_t v);
        begin_dl(v.lat, v.user, v.dmap, v.doff, v.dsize);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.start + 25'(i), 8'($urandom), v.mid_end && (i == v.n - 1));
            if (i != v.n - 1) repeat ($urandom_range(0, 2)) tick();
        end
        finish_dl(v.exp_map, v.doff, v.dsize, v.exp_ovf, v.exp_n);
    endtask

    initial begin
        int   bad, g;
        vec_t rv;

        tbl[0] = '{16,    25'h000, 3'd0, 3'd5, 4'd2, 25'h8000, 3, 1'b0, 3'd5, 1'b0, 16};
        tbl[1] = '{16,    25'h020, 3'd3, 3'd5, 4'd1, 25'h4000, 3, 1'b1, 3'd3, 1'b0, 16};
        tbl[2] = '{0,     25'h000, 3'd0, 3'd0, 4'd0, 25'h0,    2, 1'b0, 3'd0, 1'b0, 0};
        tbl[3] = '{'h200, 25'h000, 3'd0, 3'd2, 4'd0, 25'h100,  1, 1'b0, 3'd2, 1'b1, 256};
        tbl[4] = '{8,     25'h0FC, 3'd7, 3'd1, 4'd3, 25'h100,  4, 1'b0, 3'd7, 1'b1, 4};
        tbl[5] = '{4,     25'h100, 3'd0, 3'd4, 4'd0, 25'h0,    2, 1'b1, 3'd4, 1'b1, 0};

        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; det_mapper = '0; det_offset = '0;
        det_size = '0; user_mapper = '0;
        repeat (3) tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_wait", ioctl_wait, 0);
        check("rst_det_we", det_we, 0);
        check("rst_isrom", det_isROM, 0);
        check("rst_valid", cart_valid, 0);
        check("rst_cart_reset", cart_reset, 0);
        check("rst_overflow", overflow, 0);
        check("rst_cart_size", cart_size, 0);
        check("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick();

        // Ack with no request outstanding must be ignored.
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();
        check("spur_ack_req", mem_req, 0);
        check("spur_ack_det_we", det_we, 0);

        // Download on another index must not start a load.
        ioctl_index = 8'h02; ioctl_download = 1'b1;
        repeat (3) tick();
        check("other_index", det_isROM, 0);
        ioctl_download = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) do_download(tbl[k]);

        // Reset while a write is outstanding aborts without commit.
        begin_dl(4, 3'd0, 3'd1, 4'd0, 25'h10);
        ioctl_wr = 1'b1; ioctl_addr = 25'h5; ioctl_dout = 8'hA5;
        tick();
        ioctl_wr = 1'b0;
        check("abort_in_write", mem_req, 1);
        reset = 1'b1; ioctl_download = 1'b0;
        tick();
        check("abort_req", mem_req, 0);
        check("abort_wait", ioctl_wait, 0);
        check("abort_valid", cart_valid, 0);
        check("abort_isrom", det_isROM, 0);
        check("abort_mapper", cart_mapper, 0);
        reset = 1'b0;
        repeat (12) tick();
        check("abort_no_commit", cart_valid, 0);
        check("abort_no_reset", cart_reset, 0);

        // Second download raised while the reset pulse is running.
        begin_dl(2, 3'd0, 3'd6, 4'd1, 25'h40);
        send_byte(25'h0, 8'h11, 1'b0);
        ioctl_download = 1'b0;
        g = 0;
        while (!cart_valid && g < 200) begin tick(); g++; end
        check("rstp_first_commit", cart_valid, 1);
        repeat (3) tick();
        ioctl_download = 1'b1;
        bad = 0; g = 0;
        while (cart_reset && g < 200) begin
            tick(); g++;
            if (!cart_valid) bad++;
        end
        check("rstp_valid_held", bad, 0);
        check("rstp_idle_valid", cart_valid, 1);
        tick();
        check("rstp_pending_load_valid", cart_valid, 0);
        check("rstp_pending_load_isrom", det_isROM, 1);
        mem_q.delete(); det_q.delete(); exp_mem.delete(); exp_det.delete();
        user_mapper = 3'd0;
        for (int i = 0; i < 3; i++) send_byte(25'(i), 8'($urandom), 1'b0);
        finish_dl(3'd6, 4'd1, 25'h40, 1'b0, 3);

        // Random downloads against the byte-level model.
        for (int r = 0; r < 8; r++) begin
            rv.n       = $urandom_range(0, 20);
            rv.start   = 25'($urandom_range(200, 270));
            rv.user    = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            rv.dmap    = 3'($urandom);
            rv.doff    = 4'($urandom);
            rv.dsize   = 25'($urandom);
            rv.lat     = $urandom_range(1, 4);
            rv.mid_end = (rv.n > 0) && ($urandom_range(0, 1) == 1);
            rv.exp_n   = 0;
            rv.exp_ovf = 1'b0;
            for (int i = 0; i < rv.n; i++) begin
                if (rv.start + 25'(i) < MAX) rv.exp_n++;
                else rv.exp_ovf = 1'b1;
            end
            rv.exp_map = (rv.user != 3'd0) ? rv.user : rv.dmap;
            do_download(rv);
        end

        check("req_stable", stab_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
